// File: rtl/rsa_job_sequencer.sv
// rsa_job_sequencer: accepts RSA jobs, sequences the inverter and
// mod_exp phases of the control core, and returns the result block.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   job_valid/job_ready       upstream job handshake
//   job_p, job_q, job_mode    primes and encrypt_decrypt for the job
//   job_msg                   message block (2*WIDTH)
//   ctl_p, ctl_q, ctl_msg_in  registered operands to the core
//   ctl_encrypt_decrypt       registered mode to the core
//   ctl_reset_inverter        one-cycle inverter start pulse
//   ctl_reset_mod_exp         one-cycle mod_exp start pulse
//   ctl_inverter_finish       inverter done from the core
//   ctl_mod_exp_finish        mod_exp done from the core
//   ctl_msg_out               core result
//   res_valid/res_ready       downstream result handshake
//   res_msg, res_err          result block, timeout flag
module rsa_job_sequencer #(
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [WIDTH-1:0]   job_p,
  input  logic [WIDTH-1:0]   job_q,
  input  logic               job_mode,
  input  logic [2*WIDTH-1:0] job_msg,
  output logic [WIDTH-1:0]   ctl_p,
  output logic [WIDTH-1:0]   ctl_q,
  output logic [2*WIDTH-1:0] ctl_msg_in,
  output logic               ctl_encrypt_decrypt,
  output logic               ctl_reset_inverter,
  output logic               ctl_reset_mod_exp,
  input  logic               ctl_inverter_finish,
  input  logic               ctl_mod_exp_finish,
  input  logic [2*WIDTH-1:0] ctl_msg_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_msg,
  output logic               res_err
);

  typedef enum logic [2:0] {
    IDLE,
    INV_PULSE,
    INV_WAIT,
    EXP_PULSE,
    EXP_WAIT,
    OUT
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic          key_ok_q;

  logic accept;
  logic key_hit;
  logic armed;
  logic in_wait;
  logic inv_done;
  logic exp_done;
  logic expired;
  logic tmo;

  assign job_ready          = (state_q == IDLE);
  assign ctl_reset_inverter = (state_q == INV_PULSE);
  assign ctl_reset_mod_exp  = (state_q == EXP_PULSE);
  assign res_valid          = (state_q == OUT);

  assign accept  = job_valid && job_ready;
  assign key_hit = key_ok_q && (job_p == ctl_p)
                && (job_q == ctl_q);

  // First cycle of a wait has cnt_q==0; a finish seen then
  // is left over from the previous operation.
  assign armed    = (cnt_q != '0);
  assign in_wait  = (state_q == INV_WAIT)
                 || (state_q == EXP_WAIT);
  assign inv_done = (state_q == INV_WAIT)
                 && armed && ctl_inverter_finish;
  assign exp_done = (state_q == EXP_WAIT)
                 && armed && ctl_mod_exp_finish;
  assign expired  = (cnt_q == CNT_LAST);
  // Finish beats timeout in the same cycle.
  assign tmo      = in_wait && expired
                 && !inv_done && !exp_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = key_hit ? EXP_PULSE : INV_PULSE;
        end
      end
      INV_PULSE: state_d = INV_WAIT;
      INV_WAIT: begin
        if (inv_done) begin
          state_d = EXP_PULSE;
        end else if (tmo) begin
          state_d = OUT;
        end
      end
      EXP_PULSE: state_d = EXP_WAIT;
      EXP_WAIT: begin
        if (exp_done || tmo) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_p               <= '0;
      ctl_q               <= '0;
      ctl_msg_in          <= '0;
      ctl_encrypt_decrypt <= 1'b0;
      cnt_q               <= '0;
      key_ok_q            <= 1'b0;
      res_msg             <= '0;
      res_err             <= 1'b0;
    end else begin
      if (accept) begin
        ctl_p               <= job_p;
        ctl_q               <= job_q;
        ctl_msg_in          <= job_msg;
        ctl_encrypt_decrypt <= job_mode;
      end
      // Counts only while staying in a wait state, so it
      // reads zero on the first cycle of every wait.
      if (in_wait && (state_d == state_q)) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
      if (inv_done) begin
        key_ok_q <= 1'b1;
      end else if (tmo) begin
        key_ok_q <= 1'b0;
      end
      if (exp_done) begin
        res_msg <= ctl_msg_out;
        res_err <= 1'b0;
      end else if (tmo) begin
        res_msg <= '0;
        res_err <= 1'b1;
      end
    end
  end

endmodule
